// File: rtl/b230519cs_richie_3.sv
// b230519cs_richie_3: 8-bit ALU (add, sub, shl, xor) with a registered 9-bit result
// y[8] carries the carry, borrow or shifted-out bit
module b230519cs_richie_3 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] sel,
    output logic [8:0] y
);
    logic [8:0] nxt;
    always_comb
        nxt = sel == 2'b00 ? {1'b0, a} + {1'b0, b} :
              sel == 2'b01 ? {1'b0, a} - {1'b0, b} :
              sel == 2'b10 ? {a, 1'b0} :
                             {1'b0, a ^ b};
    always_ff @(posedge clk or posedge rst)
        if (rst) y <= '0;
        else     y <= nxt;
endmodule

// File: tb/tb_b230519cs_richie_3.sv
// tb_b230519cs_richie_3: directed corners plus random vectors against an arithmetic model
module tb_b230519cs_richie_3;
    logic       clk = 0;
    logic       rst = 0;
    logic [7:0] a = 0, b = 0;
    logic [1:0] sel = 0;
    logic [8:0] y;
    int total = 0, bad = 0;

    b230519cs_richie_3 dut (.clk(clk), .rst(rst), .a(a), .b(b), .sel(sel), .y(y));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] model(input int x, input int z, input int s);
        int r;
        case (s)
            0: r = x + z;
            1: r = (x - z + 512) % 512;
            2: r = x * 2;
            default: r = x ^ z;
        endcase
        return r[8:0];
    endfunction

    task automatic op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                      input logic [1:0] ts, input logic [8:0] exp);
        @(negedge clk);
        a = ta; b = tb_; sel = ts;
        @(posedge clk);
        #1 chk(tag, y, exp);
    endtask

    initial begin
        logic [7:0] cv [6];
        cv = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};
        #1 rst = 1;
        #1 chk("rst_async_initial", y, 9'h000);
        @(posedge clk); #1 chk("rst_hold", y, 9'h000);
        @(negedge clk) rst = 0;
        #1 chk("rst_release_no_edge", y, 9'h000);

        op("ex_add", 8'h3F, 8'h03, 2'b00, 9'h042);
        op("ex_sub", 8'h3F, 8'h03, 2'b01, 9'h03C);
        op("ex_shl", 8'h3F, 8'h03, 2'b10, 9'h07E);
        op("ex_xor", 8'h3F, 8'h03, 2'b11, 9'h03C);
        op("add_carry", 8'hFF, 8'h01, 2'b00, 9'h100);
        op("sub_borrow", 8'h00, 8'h01, 2'b01, 9'h1FF);
        op("sub_equal", 8'hA5, 8'hA5, 2'b01, 9'h000);
        op("shl_out", 8'h80, 8'hFF, 2'b10, 9'h100);
        op("shl_ff", 8'hFF, 8'h00, 2'b10, 9'h1FE);
        op("xor_ff", 8'hFF, 8'hFF, 2'b11, 9'h000);

        // async clear mid-cycle while y is nonzero, with a vector already staged
        op("pre_rst", 8'hFF, 8'h01, 2'b00, 9'h100);
        @(negedge clk);
        a = 8'h12; b = 8'h34; sel = 2'b00;
        #1 rst = 1;
        #1 chk("rst_mid_cycle", y, 9'h000);
        @(posedge clk); #1 chk("rst_discard", y, 9'h000);
        @(posedge clk); #1 chk("rst_stay", y, 9'h000);
        @(negedge clk) rst = 0;
        @(posedge clk); #1 chk("post_rst_first", y, 9'h046);

        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 6; i++)
                for (int j = 0; j < 6; j++)
                    op("corner", cv[i], cv[j], 2'(s), model(cv[i], cv[j], s));

        for (int n = 0; n < 4000; n++) begin
            int ra, rb, rs;
            ra = $urandom_range(255); rb = $urandom_range(255); rs = $urandom_range(3);
            op("rand", 8'(ra), 8'(rb), 2'(rs), model(ra, rb, rs));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
